// File: rtl/ctrl_xfer_unit.sv
// Control-transfer resolver beside the PC: decodes JAL/JALR/BRANCH, returns
// redirect and link results during the PC hold cycle, and counts branches.
//
// Ports:
//   CLK, RESET            clock, async active-low reset
//   IP, imem_addr         instruction address in, passed to instruction memory
//   imem_rdata            instruction word (same-cycle read)
//   OP                    opcode to the PC (NOP_OP while resolving)
//   rs1_addr/rs2_addr     register file read addresses
//   rs1_val/rs2_val       register file read data
//   b_taken, up_amt       registered redirect flag and PC offset
//   link_we/rd/data       registered link register write
//   br_cnt, tk_cnt        saturating resolved / taken counters
module ctrl_xfer_unit #(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned CNT_W  = 16,
   parameter logic [6:0]  NOP_OP = 7'b0010011
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic [XLEN-1:0]  IP,
   output logic [XLEN-1:0]  imem_addr,
   input  logic [31:0]      imem_rdata,
   output logic [6:0]       OP,
   output logic [4:0]       rs1_addr,
   output logic [4:0]       rs2_addr,
   input  logic [XLEN-1:0]  rs1_val,
   input  logic [XLEN-1:0]  rs2_val,
   output logic             b_taken,
   output logic [XLEN-1:0]  up_amt,
   output logic             link_we,
   output logic [4:0]       link_rd,
   output logic [XLEN-1:0]  link_data,
   output logic [CNT_W-1:0] br_cnt,
   output logic [CNT_W-1:0] tk_cnt
);

   localparam logic [6:0] OPC_JAL  = 7'b1101111;
   localparam logic [6:0] OPC_JALR = 7'b1100111;
   localparam logic [6:0] OPC_BR   = 7'b1100011;

   typedef enum logic {RUN, RESOLVE} state_e;

   state_e state_q, state_d;

   logic             b_taken_q, b_taken_d;
   logic [XLEN-1:0]  up_amt_q, up_amt_d;
   logic             link_we_q, link_we_d;
   logic [4:0]       link_rd_q, link_rd_d;
   logic [XLEN-1:0]  link_data_q, link_data_d;
   logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
   logic [CNT_W-1:0] tk_cnt_q, tk_cnt_d;

   logic [31:0]     ins;
   logic [6:0]      op_w;
   logic [2:0]      funct3;
   logic [4:0]      rd;
   logic            is_jal, is_jalr, is_br, is_ctrl;
   logic [XLEN-1:0] imm_j, imm_b, imm_i;
   logic [XLEN-1:0] jalr_tgt;
   logic            eq, lt, ltu;
   logic            res_taken, res_lwe;
   logic [XLEN-1:0] res_up;

   assign ins       = imem_rdata;
   assign imem_addr = IP;
   assign rs1_addr  = ins[19:15];
   assign rs2_addr  = ins[24:20];
   assign funct3    = ins[14:12];
   assign rd        = ins[11:7];

   // Masking the opcode while resolving keeps the held IP from re-triggering.
   assign op_w = (state_q == RUN) ? ins[6:0] : NOP_OP;
   assign OP   = op_w;

   assign is_jal  = (op_w == OPC_JAL);
   assign is_jalr = (op_w == OPC_JALR);
   assign is_br   = (op_w == OPC_BR);
   assign is_ctrl = is_jal | is_jalr | is_br;

   assign imm_j = {{(XLEN-21){ins[31]}}, ins[31], ins[19:12],
                   ins[20], ins[30:21], 1'b0};
   assign imm_b = {{(XLEN-13){ins[31]}}, ins[31], ins[7],
                   ins[30:25], ins[11:8], 1'b0};
   assign imm_i = {{(XLEN-12){ins[31]}}, ins[31:20]};

   assign jalr_tgt = (rs1_val + imm_i) & {{(XLEN-1){1'b1}}, 1'b0};

   assign eq  = (rs1_val == rs2_val);
   assign lt  = ($signed(rs1_val) < $signed(rs2_val));
   assign ltu = (rs1_val < rs2_val);

   always_comb begin
      res_taken = 1'b0;
      res_up    = '0;
      res_lwe   = 1'b0;
      unique case (1'b1)
         is_jal: begin
            res_taken = 1'b1;
            res_up    = imm_j;
            res_lwe   = (rd != 5'd0);
         end
         is_jalr: begin
            res_taken = 1'b1;
            res_up    = jalr_tgt - IP;
            res_lwe   = (rd != 5'd0);
         end
         is_br: begin
            res_up = imm_b;
            case (funct3)
               3'b000:  res_taken = eq;
               3'b001:  res_taken = ~eq;
               3'b100:  res_taken = lt;
               3'b101:  res_taken = ~lt;
               3'b110:  res_taken = ltu;
               3'b111:  res_taken = ~ltu;
               default: res_up    = '0;
            endcase
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      b_taken_d   = b_taken_q;
      up_amt_d    = up_amt_q;
      link_we_d   = link_we_q;
      link_rd_d   = link_rd_q;
      link_data_d = link_data_q;
      br_cnt_d    = br_cnt_q;
      tk_cnt_d    = tk_cnt_q;
      unique case (state_q)
         RUN: begin
            if (is_ctrl) begin
               state_d     = RESOLVE;
               b_taken_d   = res_taken;
               up_amt_d    = res_up;
               link_we_d   = res_lwe;
               link_rd_d   = rd;
               link_data_d = IP + XLEN'(4);
               if (br_cnt_q != '1)
                  br_cnt_d = br_cnt_q + CNT_W'(1);
               if (res_taken && (tk_cnt_q != '1))
                  tk_cnt_d = tk_cnt_q + CNT_W'(1);
            end
         end
         RESOLVE: begin
            state_d   = RUN;
            b_taken_d = 1'b0;
            up_amt_d  = '0;
            link_we_d = 1'b0;
         end
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q     <= RUN;
         b_taken_q   <= 1'b0;
         up_amt_q    <= '0;
         link_we_q   <= 1'b0;
         link_rd_q   <= '0;
         link_data_q <= '0;
         br_cnt_q    <= '0;
         tk_cnt_q    <= '0;
      end else begin
         state_q     <= state_d;
         b_taken_q   <= b_taken_d;
         up_amt_q    <= up_amt_d;
         link_we_q   <= link_we_d;
         link_rd_q   <= link_rd_d;
         link_data_q <= link_data_d;
         br_cnt_q    <= br_cnt_d;
         tk_cnt_q    <= tk_cnt_d;
      end
   end

   assign b_taken   = b_taken_q;
   assign up_amt    = up_amt_q;
   assign link_we   = link_we_q;
   assign link_rd   = link_rd_q;
   assign link_data = link_data_q;
   assign br_cnt    = br_cnt_q;
   assign tk_cnt    = tk_cnt_q;

endmodule

// File: tb/tb_ctrl_xfer_unit.sv
// Scoreboard bench for ctrl_xfer_unit: directed and random control transfers
// checked against a field-level reference model; a 2-bit-counter copy checks saturation.
module tb_ctrl_xfer_unit;

   localparam logic [6:0] NOP = 7'b0010011;

   logic        CLK = 1'b0;
   logic        RESET = 1'b0;
   logic [31:0] IP;
   logic [31:0] imem_rdata;
   logic [31:0] regs [32];

   logic [31:0] imem_addr, up_amt, link_data, rs1_val, rs2_val;
   logic [6:0]  OP;
   logic [4:0]  rs1_addr, rs2_addr, link_rd;
   logic        b_taken, link_we;
   logic [15:0] br_cnt, tk_cnt;

   logic [31:0] s_imem_addr, s_up_amt, s_link_data, s_rs1_val, s_rs2_val;
   logic [6:0]  s_OP;
   logic [4:0]  s_rs1_addr, s_rs2_addr, s_link_rd;
   logic        s_b_taken, s_link_we;
   logic [1:0]  s_br_cnt, s_tk_cnt;

   assign rs1_val   = regs[rs1_addr];
   assign rs2_val   = regs[rs2_addr];
   assign s_rs1_val = regs[s_rs1_addr];
   assign s_rs2_val = regs[s_rs2_addr];

   always #5 CLK = ~CLK;

   ctrl_xfer_unit #(.XLEN(32), .CNT_W(16), .NOP_OP(NOP)) dut (
      .CLK(CLK), .RESET(RESET), .IP(IP), .imem_addr(imem_addr),
      .imem_rdata(imem_rdata), .OP(OP), .rs1_addr(rs1_addr),
      .rs2_addr(rs2_addr), .rs1_val(rs1_val), .rs2_val(rs2_val),
      .b_taken(b_taken), .up_amt(up_amt), .link_we(link_we),
      .link_rd(link_rd), .link_data(link_data), .br_cnt(br_cnt),
      .tk_cnt(tk_cnt)
   );

   ctrl_xfer_unit #(.XLEN(32), .CNT_W(2), .NOP_OP(NOP)) u_sat (
      .CLK(CLK), .RESET(RESET), .IP(IP), .imem_addr(s_imem_addr),
      .imem_rdata(imem_rdata), .OP(s_OP), .rs1_addr(s_rs1_addr),
      .rs2_addr(s_rs2_addr), .rs1_val(s_rs1_val), .rs2_val(s_rs2_val),
      .b_taken(s_b_taken), .up_amt(s_up_amt), .link_we(s_link_we),
      .link_rd(s_link_rd), .link_data(s_link_data), .br_cnt(s_br_cnt),
      .tk_cnt(s_tk_cnt)
   );

   typedef struct {
      logic        taken;
      logic [31:0] up;
      logic        lwe;
      logic [4:0]  lrd;
      logic [31:0] ldata;
      int          br;
      int          tk;
      int          sbr;
      int          stk;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   mbr = 0, mtk = 0, msbr = 0, mstk = 0;
   bit   resolving = 1'b0;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h t=%0t", nm, act, req, $time);
      end
   endtask

   function automatic int sat_inc(int v, int w);
      int mx = (1 << w) - 1;
      return (v >= mx) ? mx : v + 1;
   endfunction

   function automatic logic [31:0] enc_jal(logic [4:0] rd, logic [31:0] off);
      return {off[20], off[10:1], off[11], off[19:12], rd, 7'b1101111};
   endfunction

   function automatic logic [31:0] enc_jalr(logic [4:0] rd, logic [4:0] rs1,
                                            logic [31:0] imm);
      return {imm[11:0], rs1, 3'b000, rd, 7'b1100111};
   endfunction

   function automatic logic [31:0] enc_br(logic [2:0] f3, logic [4:0] rs1,
                                          logic [4:0] rs2, logic [31:0] off);
      return {off[12], off[10:5], rs2, rs1, f3, off[4:1], off[11], 7'b1100011};
   endfunction

   // Present one word for one cycle; a control word seen in RUN yields one
   // expected resolution in the following cycle.
   task automatic present(logic [31:0] word, logic [31:0] ip, bit ctrl, exp_t e);
      bit nxt = 1'b0;
      imem_rdata = word;
      IP = ip;
      if (!resolving && ctrl) begin
         mbr  = sat_inc(mbr, 16);
         msbr = sat_inc(msbr, 2);
         if (e.taken) begin
            mtk  = sat_inc(mtk, 16);
            mstk = sat_inc(mstk, 2);
         end
         e.br = mbr; e.tk = mtk; e.sbr = msbr; e.stk = mstk;
         sb.push_back(e);
         nxt = 1'b1;
      end
      @(posedge CLK);
      #1;
      resolving = nxt;
   endtask

   task automatic do_jal(logic [4:0] rd, logic [31:0] off, logic [31:0] ip);
      exp_t e;
      e = '{default: 0};
      e.taken = 1'b1; e.up = off; e.lwe = (rd != 0);
      e.lrd = rd; e.ldata = ip + 32'd4;
      present(enc_jal(rd, off), ip, 1'b1, e);
   endtask

   task automatic do_jalr(logic [4:0] rd, logic [4:0] rs1, logic [31:0] imm,
                          logic [31:0] ip);
      exp_t e;
      e = '{default: 0};
      e.taken = 1'b1;
      e.up = ((regs[rs1] + imm) & 32'hFFFF_FFFE) - ip;
      e.lwe = (rd != 0); e.lrd = rd; e.ldata = ip + 32'd4;
      present(enc_jalr(rd, rs1, imm), ip, 1'b1, e);
   endtask

   task automatic do_br(logic [2:0] f3, logic [4:0] rs1, logic [4:0] rs2,
                        logic [31:0] off, logic [31:0] ip);
      exp_t        e;
      logic [31:0] a, b, w;
      a = regs[rs1];
      b = regs[rs2];
      w = enc_br(f3, rs1, rs2, off);
      e = '{default: 0};
      e.up = off;
      case (f3)
         3'd0: e.taken = (a == b);
         3'd1: e.taken = (a != b);
         3'd4: e.taken = ($signed(a) < $signed(b));
         3'd5: e.taken = ($signed(a) >= $signed(b));
         3'd6: e.taken = (a < b);
         3'd7: e.taken = (a >= b);
         default: begin e.taken = 1'b0; e.up = 32'd0; end
      endcase
      e.lwe = 1'b0; e.lrd = w[11:7]; e.ldata = ip + 32'd4;
      present(w, ip, 1'b1, e);
   endtask

   task automatic do_other(logic [31:0] ip);
      exp_t        e;
      logic [31:0] w;
      logic [6:0]  ops [5];
      ops = '{7'b0110011, 7'b0000011, 7'b0100011, 7'b0110111, 7'b0010111};
      e = '{default: 0};
      w = $urandom;
      w[6:0] = ops[$urandom_range(0, 4)];
      present(w, ip, 1'b0, e);
   endtask

   // Monitor: a NOP opcode marks a resolve cycle, since stimulus never
   // presents a NOP-opcode word in RUN.
   initial begin
      exp_t e;
      forever begin
         @(negedge CLK);
         if (OP === NOP) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_resolve actual=1 required=0 t=%0t", $time);
            end else begin
               e = sb.pop_front();
               chk("b_taken", 32'(b_taken), 32'(e.taken));
               chk("up_amt", up_amt, e.up);
               chk("link_we", 32'(link_we), 32'(e.lwe));
               chk("link_rd", 32'(link_rd), 32'(e.lrd));
               chk("link_data", link_data, e.ldata);
               chk("br_cnt", 32'(br_cnt), e.br);
               chk("tk_cnt", 32'(tk_cnt), e.tk);
               chk("sat_br_cnt", 32'(s_br_cnt), e.sbr);
               chk("sat_tk_cnt", 32'(s_tk_cnt), e.stk);
            end
         end else begin
            chk("op_run", 32'(OP), 32'(imem_rdata[6:0]));
            chk("imem_addr", imem_addr, IP);
            chk("rs1_addr", 32'(rs1_addr), 32'(imem_rdata[19:15]));
            chk("rs2_addr", 32'(rs2_addr), 32'(imem_rdata[24:20]));
            chk("b_taken_idle", 32'(b_taken), 32'd0);
            chk("link_we_idle", 32'(link_we), 32'd0);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] r, ip, off;
      logic [4:0]  a1, a2, rd;
      for (int i = 0; i < 32; i++) regs[i] = 32'd0;
      IP = 32'd0;
      imem_rdata = 32'h0000_0033;
      #12;
      chk("rst_b_taken", 32'(b_taken), 32'd0);
      chk("rst_up_amt", up_amt, 32'd0);
      chk("rst_link_we", 32'(link_we), 32'd0);
      chk("rst_link_rd", 32'(link_rd), 32'd0);
      chk("rst_link_data", link_data, 32'd0);
      chk("rst_br_cnt", 32'(br_cnt), 32'd0);
      chk("rst_tk_cnt", 32'(tk_cnt), 32'd0);
      #11 RESET = 1'b1;
      @(posedge CLK);
      #1;

      regs[1] = 32'd5; regs[2] = 32'd5;
      do_br(3'd0, 5'd1, 5'd2, 32'd16, 32'h20);
      do_other(32'h24);
      regs[3] = 32'h1003;
      do_jalr(5'd1, 5'd3, 32'd4, 32'h40);
      do_other(32'h44);
      regs[4] = 32'hFFFF_FFFF; regs[5] = 32'd1;
      do_br(3'd4, 5'd4, 5'd5, 32'h40, 32'h60);
      do_other(32'h64);
      do_br(3'd6, 5'd4, 5'd5, 32'h40, 32'h68);
      do_other(32'h6C);
      do_jal(5'd0, 32'hFFFF_FFF8, 32'h70);
      do_other(32'h74);

      regs[6] = 32'd1; regs[7] = 32'd2;
      do_br(3'd1, 5'd6, 5'd7, 32'h20, 32'h80);
      do_jal(5'd5, 32'h100, 32'h80);
      do_jal(5'd5, 32'h100, 32'h80);
      do_other(32'h84);

      do_jal(5'd2, 32'h8, 32'h90);
      #1 RESET = 1'b0;
      #1;
      chk("arst_b_taken", 32'(b_taken), 32'd0);
      chk("arst_up_amt", up_amt, 32'd0);
      chk("arst_link_we", 32'(link_we), 32'd0);
      chk("arst_link_data", link_data, 32'd0);
      chk("arst_br_cnt", 32'(br_cnt), 32'd0);
      chk("arst_tk_cnt", 32'(tk_cnt), 32'd0);
      chk("arst_op_run", 32'(OP), 32'(imem_rdata[6:0]));
      sb.delete();
      mbr = 0; mtk = 0; msbr = 0; mstk = 0;
      resolving = 1'b0;
      @(posedge CLK);
      #3 RESET = 1'b1;
      do_br(3'd2, 5'd1, 5'd2, 32'h30, 32'hA0);
      do_other(32'hA4);

      for (int i = 0; i < 5; i++) do_jal(5'd1, 32'h10, 32'hB0 + 32'(i * 16));
      do_other(32'hC0);

      repeat (300) begin
         r  = $urandom;
         ip = $urandom & 32'hFFFF_FFFC;
         a1 = 5'($urandom_range(1, 31));
         a2 = 5'($urandom_range(1, 31));
         rd = 5'($urandom_range(0, 31));
         regs[a1] = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
         regs[a2] = ($urandom_range(0, 2) == 0) ? regs[a1] : $urandom;
         case ($urandom_range(0, 4))
            0: begin
               off = {{11{r[20]}}, r[20:1], 1'b0};
               do_jal(rd, off, ip);
            end
            1: begin
               off = {{20{r[11]}}, r[11:0]};
               do_jalr(rd, a1, off, ip);
            end
            2, 3: begin
               off = {{19{r[12]}}, r[12:1], 1'b0};
               do_br(3'($urandom_range(0, 7)), a1, a2, off, ip);
            end
            default: do_other(ip);
         endcase
      end
      do_other(32'h0);
      do_other(32'h4);
      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ctrl_xfer_unit.md
Name: ctrl_xfer_unit

Overview:
- Instruction-side companion to the program counter. It presents the instruction at IP and drives OP to the PC.
- On a control transfer (JAL, JALR, BRANCH) it resolves the branch and returns b_taken and up_amt during the PC's one-cycle hold/stall window.
- It also produces the link write for JAL and JALR, and keeps branch statistics counters.
- Sits between the PC, a combinational-read instruction memory, and the register file read ports.

Parameters:
- XLEN, 32, datapath and address width
- CNT_W, 16, width of the statistics counters (saturating)
- NOP_OP, 7'b0010011, opcode driven on OP while resolving

Ports:
- CLK  in  1  clock, all state updates on rising edge
- RESET  in  1  asynchronous, active-low reset (0 = reset asserted)
- IP  in  XLEN  current instruction address from the PC
- imem_addr  out  XLEN  instruction memory address, equal to IP (combinational)
- imem_rdata  in  32  instruction word, valid in the same cycle as imem_addr
- OP  out  7  opcode to the PC
- rs1_addr  out  5  register file read address, instr[19:15]
- rs2_addr  out  5  register file read address, instr[24:20]
- rs1_val  in  XLEN  register file data for rs1_addr (combinational)
- rs2_val  in  XLEN  register file data for rs2_addr (combinational)
- b_taken  out  1  redirect flag, registered
- up_amt  out  XLEN  PC offset for the redirect, registered
- link_we  out  1  write enable for the link register
- link_rd  out  5  destination register for the link write
- link_data  out  XLEN  link value, IP+4 of the control instruction
- br_cnt  out  CNT_W  count of resolved control transfers
- tk_cnt  out  CNT_W  count of taken control transfers

Behaviour:
- FSM states are RUN and RESOLVE. Reset places the FSM in RUN.
- Reset values: b_taken=0, up_amt=0, link_we=0, link_rd=0, link_data=0, br_cnt=0, tk_cnt=0.
- RUN state:
  - OP = imem_rdata[6:0].
  - is_ctrl = OP in {1101111 JAL, 1100111 JALR, 1100011 BRANCH}.
  - If is_ctrl, on the clock edge capture: the instruction, rs1_val, rs2_val and IP; compute the resolution into b_taken, up_amt and link outputs; move to RESOLVE.
  - Otherwise stay in RUN.
- RESOLVE state:
  - Lasts exactly one cycle and aligns with the PC stall cycle, so the PC sees the registered outputs.
  - OP = NOP_OP regardless of imem_rdata, so a control instruction at the held IP cannot re-trigger.
  - Always returns to RUN.
  - On exit, b_taken, up_amt and link_we clear to 0.
- Resolution arithmetic (all XLEN, two's complement, wrap-around on overflow):
  - JAL: taken=1; up_amt = sext({i[31],i[19:12],i[20],i[30:21],1'b0}); link_we = (rd != 0).
  - JALR: taken=1; target = (rs1_val + sext(i[31:20])) & ~1; up_amt = target - IP_captured; link_we = (rd != 0). Use the captured rs1_val, not a value updated by the link write.
  - BRANCH: up_amt = sext({i[31],i[7],i[30:25],i[11:8],1'b0}); link_we = 0.
  - BRANCH taken condition by funct3:
    - 000 BEQ: equal
    - 001 BNE: not equal
    - 100 BLT: signed less than
    - 101 BGE: signed greater or equal
    - 110 BLTU: unsigned less than
    - 111 BGEU: unsigned greater or equal
    - 010 and 011: not taken, up_amt = 0
  - link_rd = i[11:7]; link_data = IP_captured + 4.
- Counters:
  - br_cnt increments on each RUN to RESOLVE transition.
  - tk_cnt increments when the captured taken = 1.
  - Both saturate at all-ones.
- Boundary conditions:
  - A control instruction immediately after RESOLVE is detected normally in the following RUN cycle.
  - Reset asserted mid-RESOLVE: immediately returns to RUN and clears all registered outputs, with no counter update.
  - Reset deasserts asynchronously; the first edge after deassertion evaluates RUN.

Test Plan:
1. BEQ at IP=0x20, offset +16, rs1_val=rs2_val=5 -> OP=1100011 in cycle n; cycle n+1: OP=0010011, b_taken=1, up_amt=0x10, link_we=0, br_cnt=1, tk_cnt=1.
2. JALR rd=1 at IP=0x40, rs1_val=0x1003, imm=4 -> cycle n+1: b_taken=1, up_amt=0xFC6, link_we=1, link_rd=1, link_data=0x44.
3. Signed/unsigned compare with rs1=0xFFFFFFFF, rs2=1 -> BLT: b_taken=1; BLTU: b_taken=0, up_amt still equals the immediate; JAL rd=0 with offset -8: up_amt=0xFFFFFFF8, link_we=0.
4. Back-to-back: BNE, then a JAL word returned at the held IP during RESOLVE -> OP masked to NOP, only one resolution (br_cnt+1); next RUN cycle detects JAL normally.
5. RESET pulled low mid-RESOLVE -> outputs zero within the same cycle (asynchronous), FSM in RUN, counters zero; funct3=010 branch after release -> b_taken=0, up_amt=0.
6. Counter saturation with CNT_W=2: 5 taken JALs -> br_cnt=tk_cnt=3.
